cpu_trace_buffer: RTL and testbench

Parametrised on-chip trace capture for the cpu core. It samples NCHAN probe words (e.g. Pc, opcode/state, selected register) on each Sample strobe into a circular buffer of DEPTH entries. Capture stops a programmable number of samples after a masked-compare trigger. The frozen window is then streamed out oldest-first over a valid/ready port for the test interface to read. It is a successor to the simulation-only probe wiring: the same visibility, held in hardware, with trigger and post-trigger depth.

---
 rtl/cpu_debug_pkg.sv | 25 ++
 rtl/trace_ram.sv | 31 +++
 rtl/cpu_trace_buffer.sv | 167 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the cpu debug/trace blocks.
package cpu_debug_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3,
    READ  = 3'd4
  } state_t;

  // Probe channel assignment used by the core's trace wiring
  localparam int CH_PC    = 0;
  localparam int CH_IR    = 1;
  localparam int CH_STATE = 2;
  localparam int CH_REG   = 3;

  // One trace entry holds every probe channel side by side
  function automatic int trace_entry_w(input int width, input int nchan);
    return width * nchan;
  endfunction

  localparam int TRACE_ENTRY_W = trace_entry_w(16, 4);

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register file with one synchronous write port and one
// registered read port. Contents are not reset; the read register is.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Capture write into the array
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; holds its value while rd_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of the cpu probe channels with a masked-compare
// trigger, programmable post-trigger depth and oldest-first valid/ready readout.
module cpu_trace_buffer
  import cpu_debug_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCHAN = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(NCHAN),
  localparam int EW   = trace_entry_w(WIDTH, NCHAN)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [EW-1:0]    Probe,
  input  logic             Sample,
  input  logic             Arm,
  input  logic [CW-1:0]    TrigChan,
  input  logic [WIDTH-1:0] TrigValue,
  input  logic [WIDTH-1:0] TrigMask,
  input  logic [AW-1:0]    PostCount,
  input  logic             Read,
  output logic             Busy,
  output logic             Triggered,
  output logic [AW:0]      Count,
  output logic             RdValid,
  input  logic             RdReady,
  output logic [EW-1:0]    RdData,
  output logic             RdLast
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          state;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   postleft;
  logic [AW:0]     count;
  logic [AW:0]     remaining;
  logic            rd_valid;
  logic            rd_last;

  logic [WIDTH-1:0] trig_word;
  logic             match;
  logic             capture;
  logic [AW-1:0]    rd_start;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;

  // Select the trigger channel and compare only the masked bits
  always_comb begin
    trig_word = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (TrigChan == CW'(k)) trig_word = Probe[k*WIDTH +: WIDTH];
    end
    match = (((trig_word ^ TrigValue) & TrigMask) == '0);
  end

  // Writes only while capturing; Arm wins over a coincident Sample
  assign capture  = Sample && !Arm && (state == ARMED || state == POST);
  // Oldest entry; when full, count's low bits are zero so this is wptr
  assign rd_start = wptr - count[AW-1:0];

  // Read port feeds the next entry: first one on Read, then one per transfer
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = rptr;
    if (!Arm) begin
      if (state == DONE && Read && count != '0) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = rd_start;
      end else if (state == READ && rd_valid && RdReady && !rd_last) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = rptr;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_ram (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (capture),
    .wr_addr (wptr),
    .wr_data (Probe),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (RdData)
  );

  // Capture/trigger/readout state machine with pointers and counters
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      postleft  <= '0;
      count     <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else if (Arm) begin
      state    <= ARMED;
      wptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (Sample) begin
            wptr  <= wptr + 1'b1;
            count <= (count == FULL) ? count : count + 1'b1;
            if (match) begin
              postleft <= PostCount;
              state    <= (PostCount == '0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (Sample) begin
            wptr     <= wptr + 1'b1;
            count    <= (count == FULL) ? count : count + 1'b1;
            postleft <= postleft - 1'b1;
            if (postleft <= AW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (Read) begin
            if (count == '0) begin
              state <= IDLE;
            end else begin
              state     <= READ;
              rptr      <= rd_start + 1'b1;
              remaining <= count;
              rd_valid  <= 1'b1;
              rd_last   <= (count == (AW+1)'(1));
            end
          end
        end
        READ: begin
          if (rd_valid && RdReady) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              rptr      <= rptr + 1'b1;
              remaining <= remaining - 1'b1;
              rd_last   <= (remaining == (AW+1)'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state == ARMED) || (state == POST);
  assign Triggered = (state == DONE) || (state == READ);
  assign Count     = count;
  assign RdValid   = rd_valid;
  assign RdLast    = rd_last;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=8, WIDTH=16, NCHAN=4).
module tb_cpu_trace_buffer;

  localparam int WIDTH = 16;
  localparam int NCHAN = 4;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(NCHAN);
  localparam int EW    = WIDTH * NCHAN;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic [EW-1:0]    Probe = '0;
  logic             Sample = 1'b0;
  logic             Arm = 1'b0;
  logic [CW-1:0]    TrigChan = '0;
  logic [WIDTH-1:0] TrigValue = '0;
  logic [WIDTH-1:0] TrigMask = '0;
  logic [AW-1:0]    PostCount = '0;
  logic             Read = 1'b0;
  logic             Busy;
  logic             Triggered;
  logic [AW:0]      Count;
  logic             RdValid;
  logic             RdReady = 1'b1;
  logic [EW-1:0]    RdData;
  logic             RdLast;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_pc [16];

  cpu_trace_buffer #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Probe     (Probe),
    .Sample    (Sample),
    .Arm       (Arm),
    .TrigChan  (TrigChan),
    .TrigValue (TrigValue),
    .TrigMask  (TrigMask),
    .PostCount (PostCount),
    .Read      (Read),
    .Busy      (Busy),
    .Triggered (Triggered),
    .Count     (Count),
    .RdValid   (RdValid),
    .RdReady   (RdReady),
    .RdData    (RdData),
    .RdLast    (RdLast)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Full probe word for a given Pc; other channels carry derived patterns
  function automatic logic [63:0] entry(input logic [15:0] pc);
    return {pc ^ 16'h00F0, pc + 16'h1000, ~pc, pc};
  endfunction

  task automatic do_sample(input logic [15:0] pc);
    Probe  = entry(pc);
    Sample = 1'b1;
    tick();
    Sample = 1'b0;
  endtask

  task automatic arm_pulse();
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
  endtask

  // Read n entries listed in exp_pc; stall for 3 cycles on entry stall_idx
  task automatic readout(input string tag, input int n, input int stall_idx);
    int w;
    logic [63:0] held;
    RdReady = 1'b1;
    Read = 1'b1;
    tick();
    Read = 1'b0;
    w = 0;
    while (!RdValid && w < 8) begin
      tick();
      w++;
    end
    chk({tag, " rdvalid"}, 64'(RdValid), 64'd1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), RdData, entry(exp_pc[i]));
      chk($sformatf("%s last[%0d]", tag, i), 64'(RdLast), 64'(i == n - 1));
      if (i == stall_idx) begin
        held = RdData;
        RdReady = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk($sformatf("%s hold data %0d", tag, j), RdData, held);
          chk($sformatf("%s hold valid %0d", tag, j), 64'(RdValid), 64'd1);
        end
        RdReady = 1'b1;
      end
      tick();
    end
    chk({tag, " rdvalid end"}, 64'(RdValid), 64'd0);
    chk({tag, " triggered end"}, 64'(Triggered), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst triggered", 64'(Triggered), 64'd0);
    chk("rst count", 64'(Count), 64'd0);
    chk("rst rdvalid", 64'(RdValid), 64'd0);
    chk("rst rddata", RdData, 64'd0);
    chk("rst rdlast", 64'(RdLast), 64'd0);
    Reset = 1'b0;
    tick();

    // Reset in the middle of post-trigger capture
    TrigChan = 2'd0; TrigValue = 16'h0005; TrigMask = 16'hFFFF; PostCount = 3'd3;
    arm_pulse();
    for (int p = 3; p <= 6; p++) do_sample(16'(p));
    chk("t1 busy post", 64'(Busy), 64'd1);
    chk("t1 count", 64'(Count), 64'd4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t1 busy", 64'(Busy), 64'd0);
    chk("t1 triggered", 64'(Triggered), 64'd0);
    chk("t1 count0", 64'(Count), 64'd0);
    chk("t1 rdvalid", 64'(RdValid), 64'd0);
    chk("t1 rddata", RdData, 64'd0);
    chk("t1 rdlast", 64'(RdLast), 64'd0);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    tick();
    chk("t1 read ignored", 64'(RdValid), 64'd0);
    chk("t1 still idle", 64'(Triggered), 64'd0);

    // Trigger on Pc=5, two post samples, stall on entry 2 during readout
    PostCount = 3'd2;
    arm_pulse();
    chk("t2 armed busy", 64'(Busy), 64'd1);
    for (int p = 0; p <= 6; p++) do_sample(16'(p));
    chk("t2 not yet trig", 64'(Triggered), 64'd0);
    do_sample(16'h0007);
    chk("t2 triggered", 64'(Triggered), 64'd1);
    chk("t2 busy off", 64'(Busy), 64'd0);
    chk("t2 count", 64'(Count), 64'd8);
    do_sample(16'h0008);
    do_sample(16'h0009);
    chk("t2 count kept", 64'(Count), 64'd8);
    for (int i = 0; i < 8; i++) exp_pc[i] = 16'(i);
    readout("t2", 8, 2);
    chk("t2 count retained", 64'(Count), 64'd8);

    // Wrap: trigger on 0xC with three post samples over 0x0..0x10
    TrigValue = 16'h000C; PostCount = 3'd3;
    arm_pulse();
    for (int p = 0; p <= 16; p++) do_sample(16'(p));
    chk("t3 triggered", 64'(Triggered), 64'd1);
    chk("t3 count", 64'(Count), 64'd8);
    for (int i = 0; i < 8; i++) exp_pc[i] = 16'(8 + i);
    readout("t3", 8, -1);

    // Masked compare on the top nibble, immediate DONE
    TrigValue = 16'h8000; TrigMask = 16'hF000; PostCount = 3'd0;
    arm_pulse();
    do_sample(16'h7FFF);
    chk("t4 no trig", 64'(Triggered), 64'd0);
    chk("t4 busy", 64'(Busy), 64'd1);
    do_sample(16'h8123);
    chk("t4 trig", 64'(Triggered), 64'd1);
    chk("t4 count", 64'(Count), 64'd2);
    exp_pc[0] = 16'h7FFF;
    exp_pc[1] = 16'h8123;
    readout("t4", 2, -1);

    // Arm with a coincident Sample during readout aborts and is not captured
    TrigValue = 16'h0005; TrigMask = 16'hFFFF; PostCount = 3'd1;
    arm_pulse();
    for (int p = 0; p <= 6; p++) do_sample(16'(p));
    chk("t6 trig", 64'(Triggered), 64'd1);
    chk("t6 count", 64'(Count), 64'd7);
    RdReady = 1'b1;
    Read = 1'b1;
    tick();
    Read = 1'b0;
    chk("t6 rd0", RdData, entry(16'h0000));
    tick();
    chk("t6 rd1", RdData, entry(16'h0001));
    PostCount = 3'd0;
    Probe = entry(16'h0005);
    Arm = 1'b1;
    Sample = 1'b1;
    tick();
    Arm = 1'b0;
    Sample = 1'b0;
    chk("t6 rdvalid", 64'(RdValid), 64'd0);
    chk("t6 count0", 64'(Count), 64'd0);
    chk("t6 armed", 64'(Busy), 64'd1);
    chk("t6 not trig", 64'(Triggered), 64'd0);
    do_sample(16'h0005);
    chk("t6 retrig", 64'(Triggered), 64'd1);
    chk("t6 count1", 64'(Count), 64'd1);
    exp_pc[0] = 16'h0005;
    readout("t6", 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
